imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the FPGA RISC-V decode stage.
- Decodes the format from the opcode itself, so no per-format select lines are needed.
- Produces the sign-extended XLEN immediate, a format tag and the previous immediate (LUI path).
- Supports stall, flush (nop) with a programmable hold-off, and a valid/ready handshake toward fetch.

---
 rtl/imm_pkg.sv | 42 ++++
 rtl/imm_decode.sv | 83 ++++++++
 rtl/imm_gen_pipe.sv | 127 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the pipelined immediate generator.
//   - format tags driven on imm_gen_pipe.fmt
//   - RISC-V major opcodes that carry an immediate
//   - flush hold-off state encoding
package imm_pkg;

    // Format tags
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct3 values of the immediate shifts (slli / srli / srai)
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    // Flush hold-off controller
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRX);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate decoder.
// Derives the format from the opcode and builds the XLEN-wide immediate.
// Ports:
//   inst  in   32    instruction word
//   imm   out  XLEN  sign-extended immediate (zero-extended shamt for FMT_SH)
//   fmt   out  3     format tag (imm_pkg FMT_*)
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHAMT_MODE = 1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt
);

    logic [6:0] op;
    logic [2:0] f3;
    logic       op_imm32;
    logic       is_shift;
    logic [5:0] shamt;

    assign op = inst[6:0];
    assign f3 = inst[14:12];

    // OP-IMM-32 only exists on RV64; on RV32 that opcode decodes as FMT_NONE.
    assign op_imm32 = (XLEN == 64) && (op == OP_IMM32);
    assign is_shift = (SHAMT_MODE != 0) && ((op == OP_IMM) || op_imm32) && is_shift_f3(f3);

    // The *W shifts and all RV32 shifts only have a 5-bit shift amount.
    assign shamt = ((XLEN == 32) || op_imm32) ? {1'b0, inst[24:20]} : inst[25:20];

    // Every immediate is at most 32 bits wide before sign extension, so each
    // one is assembled as a signed 32-bit value and widened with a cast.
    logic signed [31:0] i32, s32, b32, u32, j32;

    assign i32 = {{20{inst[31]}}, inst[31:20]};
    assign s32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u32 = {inst[31:12], 12'b0};
    assign j32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        imm = '0;
        fmt = FMT_NONE;
        if (is_shift) begin
            imm = XLEN'(shamt);
            fmt = FMT_SH;
        end else begin
            case (op)
                OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                    imm = XLEN'(i32);
                    fmt = FMT_I;
                end
                OP_IMM32: begin
                    if (op_imm32) begin
                        imm = XLEN'(i32);
                        fmt = FMT_I;
                    end
                end
                OP_STORE: begin
                    imm = XLEN'(s32);
                    fmt = FMT_S;
                end
                OP_BRANCH: begin
                    imm = XLEN'(b32);
                    fmt = FMT_B;
                end
                OP_LUI, OP_AUIPC: begin
                    imm = XLEN'(u32);
                    fmt = FMT_U;
                end
                OP_JAL: begin
                    imm = XLEN'(j32);
                    fmt = FMT_J;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage pipelined immediate generator for RISC-V decode.
//   S0 captures the instruction, imm_decode sits between S0 and S1,
//   S1 registers imm/fmt and keeps the previously output immediate.
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous active-high reset
//   in_valid   in   1     inst valid
//   in_ready   out  1     inst accepted this cycle
//   inst       in   32    instruction word
//   stall      in   1     freeze S0, S1, prev_imm and the hold counter
//   nop        in   1     flush S0/incoming inst, start hold-off (wins over stall)
//   out_valid  out  1     imm/fmt valid
//   imm        out  XLEN  generated immediate
//   fmt        out  3     format tag
//   prev_imm   out  XLEN  immediate held before the latest output update
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FLUSH_HOLD = 1,
    parameter int SHAMT_MODE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic            stall,
    input  logic            nop,
    output logic            out_valid,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] prev_imm
);

    localparam int         STAGES    = 1;
    localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD);

    state_e          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;

    // vld_pipe[0] is the S0 valid, vld_pipe[STAGES] is out_valid.
    logic [STAGES:0] vld_pipe;
    logic [31:0]     s0_inst;
    logic            accept;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;

    assign in_ready  = (state == ST_RUN) & ~stall & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_pipe[STAGES];

    // ---------------------------------------------------------------
    // Flush hold-off controller
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (nop) begin
            // A nop during HOLD simply restarts the count.
            cnt_nxt = HOLD_INIT;
            if (FLUSH_HOLD != 0) state_nxt = ST_HOLD;
        end else if (!stall && (state == ST_HOLD)) begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) state_nxt = ST_RUN;
        end
    end

    // ---------------------------------------------------------------
    // S0: capture register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[0] <= 1'b0;
            s0_inst     <= '0;
        end else if (nop) begin
            vld_pipe[0] <= 1'b0;
        end else if (!stall) begin
            // Not accepting (HOLD or in_valid low) drains S0 into S1.
            vld_pipe[0] <= accept;
            if (accept) s0_inst <= inst;
        end
    end

    imm_decode #(
        .XLEN       (XLEN),
        .SHAMT_MODE (SHAMT_MODE)
    ) u_dec (
        .inst (s0_inst),
        .imm  (dec_imm),
        .fmt  (dec_fmt)
    );

    // ---------------------------------------------------------------
    // S1: output register; imm/fmt/prev_imm only move on a real result
    // so a bubble leaves the last immediate visible.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES] <= 1'b0;
            imm              <= '0;
            fmt              <= FMT_NONE;
            prev_imm         <= '0;
        end else if (nop) begin
            vld_pipe[STAGES] <= 1'b0;
        end else if (!stall) begin
            vld_pipe[STAGES] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                imm      <= dec_imm;
                fmt      <= dec_fmt;
                prev_imm <= imm;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations share one stimulus stream.
//   d=0: XLEN=32 FLUSH_HOLD=2 SHAMT_MODE=1
//   d=1: XLEN=64 FLUSH_HOLD=0 SHAMT_MODE=1
//   d=2: XLEN=32 FLUSH_HOLD=1 SHAMT_MODE=0
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] prev;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, in_valid = 1'b0, stall = 1'b0, nop = 1'b0;
    logic [31:0] inst = '0;

    always #5 clk = ~clk;

    logic        a_rdy, a_ov, b_rdy, b_ov, c_rdy, c_ov;
    logic [31:0] a_imm, a_prev, c_imm, c_prev;
    logic [63:0] b_imm, b_prev;
    logic [2:0]  a_fmt, b_fmt, c_fmt;

    imm_gen_pipe #(.XLEN(32), .FLUSH_HOLD(2), .SHAMT_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .inst(inst),
        .stall(stall), .nop(nop), .out_valid(a_ov), .imm(a_imm), .fmt(a_fmt), .prev_imm(a_prev));
    imm_gen_pipe #(.XLEN(64), .FLUSH_HOLD(0), .SHAMT_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy), .inst(inst),
        .stall(stall), .nop(nop), .out_valid(b_ov), .imm(b_imm), .fmt(b_fmt), .prev_imm(b_prev));
    imm_gen_pipe #(.XLEN(32), .FLUSH_HOLD(1), .SHAMT_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_rdy), .inst(inst),
        .stall(stall), .nop(nop), .out_valid(c_ov), .imm(c_imm), .fmt(c_fmt), .prev_imm(c_prev));

    logic        o_rdy[3], o_ov[3];
    logic [63:0] o_imm[3], o_prev[3];
    logic [2:0]  o_fmt[3];
    assign o_rdy[0] = a_rdy; assign o_ov[0] = a_ov; assign o_fmt[0] = a_fmt;
    assign o_rdy[1] = b_rdy; assign o_ov[1] = b_ov; assign o_fmt[1] = b_fmt;
    assign o_rdy[2] = c_rdy; assign o_ov[2] = c_ov; assign o_fmt[2] = c_fmt;
    assign o_imm[0] = {32'b0, a_imm}; assign o_prev[0] = {32'b0, a_prev};
    assign o_imm[1] = b_imm;          assign o_prev[1] = b_prev;
    assign o_imm[2] = {32'b0, c_imm}; assign o_prev[2] = {32'b0, c_prev};

    int tests = 0;
    int fails = 0;

    function automatic int xl(input int d);   return (d == 1) ? 64 : 32; endfunction
    function automatic int hold(input int d); return (d == 0) ? 2 : (d == 1) ? 0 : 1; endfunction
    function automatic bit shm(input int d);  return d != 2; endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decoder: straight from the instruction-format rules.
    function automatic void ref_dec(input logic [31:0] w, input int xlen, input bit sm,
                                    output logic [63:0] imm, output logic [2:0] fmt);
        longint     v;
        logic [6:0] op;
        logic [2:0] f3;
        bit         w32;
        op  = w[6:0];
        f3  = w[14:12];
        w32 = (op == 7'b0011011) && (xlen == 64);
        v   = 0;
        fmt = 3'd0;
        if (sm && (op == 7'b0010011 || w32) && (f3 == 3'd1 || f3 == 3'd5)) begin
            fmt = 3'd6;
            if (xlen == 32 || w32) v = w[24:20];
            else                   v = w[25:20];
        end else if (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 ||
                     op == 7'b1110011 || w32) begin
            fmt = 3'd1; v = $signed(w[31:20]);
        end else if (op == 7'b0100011) begin
            fmt = 3'd2; v = $signed({w[31:25], w[11:7]});
        end else if (op == 7'b1100011) begin
            fmt = 3'd3; v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        end else if (op == 7'b0110111 || op == 7'b0010111) begin
            fmt = 3'd4; v = $signed({w[31:12], 12'b0});
        end else if (op == 7'b1101111) begin
            fmt = 3'd5; v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        end
        imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    // ---------------------------------------------------------------
    // Reference model: one instruction slot plus hold-off cycle count.
    // Results are pushed to the scoreboard on the edge they are produced.
    // ---------------------------------------------------------------
    exp_t        sb[3][$];
    bit          m_s0v[3];
    logic [31:0] m_s0i[3];
    int          m_cnt[3];
    logic [63:0] m_last[3];

    initial for (int d = 0; d < 3; d++) begin
        m_s0v[d] = 0; m_s0i[d] = '0; m_cnt[d] = 0; m_last[d] = '0;
    end

    function automatic bit m_ready(input int d);
        return !rst && (m_cnt[d] == 0) && !stall;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            bit   rdy;
            exp_t e;
            rdy = m_ready(d);
            if (rst) begin
                m_s0v[d] = 0; m_cnt[d] = 0; m_last[d] = '0;
            end else if (nop) begin
                m_s0v[d] = 0; m_cnt[d] = hold(d);
            end else if (!stall) begin
                if (m_s0v[d]) begin
                    ref_dec(m_s0i[d], xl(d), shm(d), e.imm, e.fmt);
                    e.prev = m_last[d];
                    sb[d].push_back(e);
                    m_last[d] = e.imm;
                end
                m_s0v[d] = in_valid && rdy;
                if (in_valid && rdy) m_s0i[d] = inst;
                if (m_cnt[d] > 0) m_cnt[d]--;
            end
        end
    end

    // ---------------------------------------------------------------
    // Monitor: on every updating edge with out_valid, pop and compare.
    // ---------------------------------------------------------------
    always @(posedge clk) begin : mon
        logic er, en, es;
        exp_t e;
        er = rst; en = nop; es = stall;
        #1;
        for (int d = 0; d < 3; d++) begin
            if (er || en) begin
                chk($sformatf("d%0d flush/reset out_valid", d), 64'(o_ov[d]), 64'd0);
                if (er) begin
                    chk($sformatf("d%0d reset imm", d),  o_imm[d],  64'd0);
                    chk($sformatf("d%0d reset fmt", d),  64'(o_fmt[d]), 64'd0);
                    chk($sformatf("d%0d reset prev", d), o_prev[d], 64'd0);
                end
            end else if (!es && o_ov[d]) begin
                if (sb[d].size() == 0) begin
                    chk($sformatf("d%0d unexpected output", d), 64'd1, 64'd0);
                end else begin
                    e = sb[d].pop_front();
                    chk($sformatf("d%0d imm", d),  o_imm[d],  e.imm);
                    chk($sformatf("d%0d fmt", d),  64'(o_fmt[d]), 64'(e.fmt));
                    chk($sformatf("d%0d prev", d), o_prev[d], e.prev);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Driver: one call per clock; in_ready checked against the model.
    // ---------------------------------------------------------------
    task automatic cyc(input logic r, input logic v, input logic [31:0] i,
                       input logic s, input logic n);
        @(negedge clk);
        rst = r; in_valid = v; inst = i; stall = s; nop = n;
        #2;
        for (int d = 0; d < 3; d++)
            chk($sformatf("d%0d in_ready", d), 64'(o_rdy[d]), 64'(m_ready(d)));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Accept one inst, then two idle cycles: the result is visible after.
    task automatic issue(input logic [31:0] i);
        cyc(1'b0, 1'b1, i, 1'b0, 1'b0);
        idle();
        idle();
    endtask

    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_JAL  = 32'h0080006F;

    logic [31:0] d_inst[7] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h123452B7,
                               32'h0080006F, 32'h4010D093, 32'h03F09093};
    logic [31:0] d_imm[7]  = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h12345000,
                               32'h00000008, 32'h00000001, 32'h0000001F};
    logic [2:0]  d_fmt[7]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
    logic [31:0] d_prev[7] = '{32'h0, 32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC,
                               32'h12345000, 32'h00000008, 32'h00000001};
    logic [6:0]  ops[12]   = '{7'b0000011, 7'b0010011, 7'b0010011, 7'b0011011, 7'b1100111,
                               7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b0110011};

    initial begin
        // Reset
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, I_ADDI, 1'b0, 1'b0);
        idle();
        chk("reset out_valid", 64'(a_ov), 64'd0);
        chk("reset imm", 64'(a_imm), 64'd0);
        chk("reset fmt", 64'(a_fmt), 64'd0);
        chk("post-reset in_ready", 64'(a_rdy), 64'd1);

        // Directed decode vectors
        for (int k = 0; k < 7; k++) begin
            issue(d_inst[k]);
            chk($sformatf("vec%0d out_valid", k), 64'(a_ov), 64'd1);
            chk($sformatf("vec%0d imm", k),  64'(a_imm),  64'(d_imm[k]));
            chk($sformatf("vec%0d fmt", k),  64'(a_fmt),  64'(d_fmt[k]));
            chk($sformatf("vec%0d prev", k), 64'(a_prev), 64'(d_prev[k]));
            if (k == 5) begin
                chk("srai rv64 shamt", b_imm, 64'h1);
                chk("srai rv64 fmt", 64'(b_fmt), 64'd6);
                chk("srai no-shamt imm", 64'(c_imm), 64'h401);
                chk("srai no-shamt fmt", 64'(c_fmt), 64'd1);
            end
            if (k == 6) begin
                chk("slli63 rv64 imm", b_imm, 64'h3F);
                chk("slli63 rv64 fmt", 64'(b_fmt), 64'd6);
                chk("slli63 no-shamt imm", 64'(c_imm), 64'h3F);
            end
        end

        // Flush with in_valid, hold-off of 2 on dut_a
        cyc(1'b0, 1'b1, I_LUI, 1'b0, 1'b1);
        idle();
        chk("flush out_valid", 64'(a_ov), 64'd0);
        chk("hold in_ready N+1", 64'(a_rdy), 64'd0);
        cyc(1'b0, 1'b1, I_ADDI, 1'b0, 1'b0);
        chk("hold in_ready N+2", 64'(a_rdy), 64'd0);
        idle();
        chk("hold in_ready N+3", 64'(a_rdy), 64'd1);
        idle();
        idle();
        chk("held inst dropped", 64'(a_ov), 64'd0);
        chk("imm held through flush", 64'(a_imm), 64'h1F);

        // Stall with a result in S1 and another inst in S0
        cyc(1'b0, 1'b1, I_LUI, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, I_JAL, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            chk($sformatf("stall%0d out_valid", k), 64'(a_ov), 64'd1);
            chk($sformatf("stall%0d imm", k), 64'(a_imm), 64'h12345000);
            chk($sformatf("stall%0d prev", k), 64'(a_prev), 64'h1F);
        end
        idle();
        chk("stall last frozen imm", 64'(a_imm), 64'h12345000);
        idle();
        chk("after stall imm", 64'(a_imm), 64'h8);
        chk("after stall fmt", 64'(a_fmt), 64'd5);
        chk("after stall prev", 64'(a_prev), 64'h12345000);

        // nop together with stall must still flush
        cyc(1'b0, 1'b1, I_ADDI, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        chk("nop+stall out_valid", 64'(a_ov), 64'd0);
        idle();
        idle();
        idle();
        chk("nop+stall inst dropped", 64'(a_ov), 64'd0);

        // Reset with out_valid=1, then reset during HOLD
        issue(I_LUI);
        chk("pre-reset out_valid", 64'(a_ov), 64'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("in_ready during reset", 64'(a_rdy), 64'd0);
        idle();
        chk("mid reset out_valid", 64'(a_ov), 64'd0);
        chk("mid reset imm", 64'(a_imm), 64'd0);
        chk("mid reset prev", 64'(a_prev), 64'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        chk("reset leaves HOLD", 64'(a_rdy), 64'd1);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 11)];
            cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, w,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
        end

        for (int k = 0; k < 4; k++) idle();
        for (int d = 0; d < 3; d++)
            chk($sformatf("d%0d scoreboard drained", d), 64'(sb[d].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
